// File: rtl/osc_pkg.sv
// Shared types and constants for the oscillator voice sequencer.
package osc_pkg;

  localparam int unsigned SAMPLE_W   = 24;
  localparam logic [23:0] PHASE_WRAP = 24'd48000 << 8;
  localparam logic [23:0] FREQ_MAX   = 24'hBB7FFF;

  typedef struct packed {
    logic        en;
    logic [23:0] freq;
    logic [15:0] gain;
  } voice_cfg_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADV,
    S_WSTART,
    S_WWAIT,
    S_GMUL,
    S_GW1,
    S_GW2,
    S_NEXT,
    S_OUT
  } state_t;

  // Frequencies at or above 48000 Hz would need more than one wrap per step.
  function automatic logic [23:0] clamp_freq(input logic [23:0] f);
    return (f > FREQ_MAX) ? FREQ_MAX : f;
  endfunction

  // One phase step; both operands are below the wrap point, so one subtract is enough.
  function automatic logic [23:0] phase_step(input logic [23:0] ph, input logic [23:0] inc);
    logic [24:0] s;
    s = {1'b0, ph} + {1'b0, inc};
    if (s >= {1'b0, PHASE_WRAP}) begin
      s = s - {1'b0, PHASE_WRAP};
    end
    return s[23:0];
  endfunction

endpackage

// File: rtl/osc_voice_regs.sv
// Per-voice configuration and phase storage: one config write port, one phase
// write port and one read port, the latter two indexed by the voice being served.
module osc_voice_regs
  import osc_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned VW         = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [VW-1:0] cfg_voice,
  input  logic          cfg_en,
  input  logic [23:0]   cfg_freq,
  input  logic [15:0]   cfg_gain,
  input  logic          ph_we,
  input  logic [23:0]   ph_wdata,
  input  logic [VW-1:0] rd_voice,
  output logic          rd_en,
  output logic [23:0]   rd_freq,
  output logic [15:0]   rd_gain,
  output logic [23:0]   rd_phase
);

  voice_cfg_t  cfg_q   [NUM_VOICES];
  logic [23:0] phase_q [NUM_VOICES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        cfg_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      if (cfg_we && (32'(cfg_voice) < NUM_VOICES)) begin
        cfg_q[cfg_voice] <= '{en: cfg_en, freq: clamp_freq(cfg_freq), gain: cfg_gain};
      end
      if (ph_we) begin
        phase_q[rd_voice] <= ph_wdata;
      end
    end
  end

  assign rd_en    = cfg_q[rd_voice].en;
  assign rd_freq  = cfg_q[rd_voice].freq;
  assign rd_gain  = cfg_q[rd_voice].gain;
  assign rd_phase = phase_q[rd_voice];

endmodule

// File: rtl/osc_voice_seq.sv
// Per-sample voice sequencer: advances each voice's phase, runs the waveform
// generator, scales by gain on the shared multiplier and mixes. OSC_MIX_SAT_EN selects a saturating mix.
module osc_voice_seq
  import osc_pkg::*;
#(
  parameter  int unsigned NUM_VOICES = 4,
  localparam int unsigned VW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          cfg_we,
  input  logic [VW-1:0] cfg_voice,
  input  logic          cfg_en,
  input  logic [23:0]   cfg_freq,
  input  logic [15:0]   cfg_gain,
  output logic          wave_start,
  output logic [15:0]   wave_x,
  input  logic          wave_finish,
  input  logic [23:0]   wave_y,
  input  logic [31:0]   wave_mult_a,
  input  logic [31:0]   wave_mult_b,
  output logic [31:0]   mult_a,
  output logic [31:0]   mult_b,
  input  logic [63:0]   mult_p,
  output logic [23:0]   mix,
  output logic          mix_valid,
  output logic          overrun
);

  localparam int unsigned ACC_W = SAMPLE_W + VW;

  state_t                    state;
  logic [VW-1:0]             v;
  logic signed [ACC_W-1:0]   acc;
  logic signed [23:0]        y_q;
  logic                      rd_en;
  logic [23:0]               rd_freq;
  logic [15:0]               rd_gain;
  logic [23:0]               rd_phase;
  logic [23:0]               ph_next_c;
  logic                      ph_we_c;
  logic [23:0]               mix_c;

  osc_voice_regs #(
    .NUM_VOICES (NUM_VOICES),
    .VW         (VW)
  ) u_regs (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_voice (cfg_voice),
    .cfg_en    (cfg_en),
    .cfg_freq  (cfg_freq),
    .cfg_gain  (cfg_gain),
    .ph_we     (ph_we_c),
    .ph_wdata  (ph_next_c),
    .rd_voice  (v),
    .rd_en     (rd_en),
    .rd_freq   (rd_freq),
    .rd_gain   (rd_gain),
    .rd_phase  (rd_phase)
  );

  assign ph_next_c = phase_step(rd_phase, rd_freq);
  assign ph_we_c   = (state == S_ADV) && rd_en;

`ifdef OSC_MIX_SAT_EN
  localparam logic signed [ACC_W-1:0] MIX_MAX = ACC_W'(24'sh7FFFFF);
  localparam logic signed [ACC_W-1:0] MIX_MIN = ACC_W'(24'sh800000);

  always_comb begin
    mix_c = acc[23:0];
    if (acc > MIX_MAX) begin
      mix_c = 24'h7FFFFF;
    end else if (acc < MIX_MIN) begin
      mix_c = 24'h800000;
    end
  end
`else
  logic unused_acc_hi;
  assign mix_c         = acc[23:0];
  assign unused_acc_hi = ^acc[ACC_W-1:24];
`endif

  // Product is a signed Q0.16-scaled sample; only bits 39:16 are meaningful.
  logic unused_mult_p;
  assign unused_mult_p = ^{mult_p[63:40], mult_p[15:0]};

  // Shared multiplier mux: generator owns it while it runs, gain scaling in GMUL.
  always_comb begin
    mult_a = '0;
    mult_b = '0;
    case (state)
      S_WWAIT: begin
        mult_a = wave_mult_a;
        mult_b = wave_mult_b;
      end
      S_GMUL: begin
        mult_a = 32'(y_q);
        mult_b = 32'(rd_gain);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      v          <= '0;
      acc        <= '0;
      y_q        <= '0;
      wave_start <= 1'b0;
      wave_x     <= '0;
      mix        <= '0;
      mix_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      wave_start <= 1'b0;
      mix_valid  <= 1'b0;
      overrun    <= tick && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (tick) begin
            acc   <= '0;
            v     <= '0;
            state <= S_ADV;
          end
        end
        S_ADV: begin
          if (rd_en) begin
            wave_start <= 1'b1;
            wave_x     <= ph_next_c[23:8];
            state      <= S_WSTART;
          end else begin
            state <= S_NEXT;
          end
        end
        S_WSTART: state <= S_WWAIT;
        S_WWAIT: begin
          if (wave_finish) begin
            y_q   <= wave_y;
            state <= S_GMUL;
          end
        end
        S_GMUL: state <= S_GW1;
        S_GW1:  state <= S_GW2;
        S_GW2: begin
          acc   <= acc + ACC_W'($signed(mult_p[39:16]));
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (v == VW'(NUM_VOICES - 1)) begin
            mix       <= mix_c;
            mix_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            v     <= v + VW'(1);
            state <= S_ADV;
          end
        end
        S_OUT:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osc_voice_seq.sv
// Self-checking bench for osc_voice_seq: table vectors, corner sequences and
// randomized frames against a sample-level reference model.
`timescale 1ns/1ps
module tb_osc_voice_seq;

  localparam int NV      = 4;
  localparam int PH_WRAP = 48000 * 256;
`ifdef OSC_MIX_SAT_EN
  localparam int E_FULL = 'h7FFFFF;
  localparam int E_NEG  = 'h800000;
`else
  localparam int E_FULL = 'hFFFDFC;
  localparam int E_NEG  = 'h400000;
`endif

  logic        clk = 1'b0;
  logic        rst, tick, cfg_we, cfg_en;
  logic [1:0]  cfg_voice;
  logic [23:0] cfg_freq;
  logic [15:0] cfg_gain;
  logic        wave_start, wave_finish;
  logic [15:0] wave_x;
  logic [23:0] wave_y;
  logic [31:0] wave_mult_a, wave_mult_b, mult_a, mult_b;
  logic [63:0] mult_p;
  logic [23:0] mix;
  logic        mix_valid, overrun;

  always #5 clk = ~clk;

  osc_voice_seq #(.NUM_VOICES(NV)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cfg_we(cfg_we), .cfg_voice(cfg_voice), .cfg_en(cfg_en),
    .cfg_freq(cfg_freq), .cfg_gain(cfg_gain),
    .wave_start(wave_start), .wave_x(wave_x),
    .wave_finish(wave_finish), .wave_y(wave_y),
    .wave_mult_a(wave_mult_a), .wave_mult_b(wave_mult_b),
    .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
    .mix(mix), .mix_valid(mix_valid), .overrun(overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Environment: waveform generator and two-stage pipelined multiplier
  int          gen_mode    = 0;
  logic [23:0] gen_const   = '0;
  int          gen_dmin    = 1;
  int          gen_dmax    = 3;
  bit          gen_check_en = 1'b1;

  function automatic logic [23:0] gen_y(input int x);
    case (gen_mode)
      0:       return 24'(x << 8);
      1:       return gen_const;
      default: return 24'(x * 40503 + 370085);
    endcase
  endfunction

  initial begin
    logic [15:0] xs;
    wave_finish = 1'b0;
    wave_y      = '0;
    wave_mult_a = 32'hDEADBEEF;
    wave_mult_b = 32'h12345678;
    forever begin
      @(negedge clk);
      if (wave_start === 1'b1) begin
        xs = wave_x;
        repeat ($urandom_range(gen_dmax, gen_dmin)) @(negedge clk);
        wave_mult_a = $urandom;
        wave_mult_b = $urandom;
        #1;
        if (gen_check_en) begin
          chk("mult_a_passthru", mult_a, wave_mult_a);
          chk("mult_b_passthru", mult_b, wave_mult_b);
        end
        wave_y      = gen_y(int'(xs));
        wave_finish = 1'b1;
        @(negedge clk);
        wave_finish = 1'b0;
      end
    end
  end

  logic [63:0] mp1, mp2;
  always @(posedge clk) begin
    mp1 <= 64'(longint'($signed(mult_a)) * longint'($signed(mult_b)));
    mp2 <= mp1;
  end
  assign mult_p = mp2;

  // Output monitors
  int n_start = 0, n_mv = 0, n_ov = 0;
  int got_x[$];
  always @(negedge clk) begin
    if (wave_start === 1'b1) begin
      n_start++;
      got_x.push_back(int'(wave_x));
    end
    if (mix_valid === 1'b1) n_mv++;
    if (overrun === 1'b1) n_ov++;
  end

  // Reference model: per-voice settings and phase, one frame at a time
  bit m_en[NV];
  int m_freq[NV], m_gain[NV], m_phase[NV];
  int exp_x[$];

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_en[i] = 1'b0; m_freq[i] = 0; m_gain[i] = 0; m_phase[i] = 0;
    end
  endtask

  task automatic model_frame(output logic [23:0] em);
    longint acc;
    int p;
    logic [23:0] y;
    acc = 0;
    exp_x.delete();
    for (int i = 0; i < NV; i++) begin
      if (m_en[i]) begin
        p = m_phase[i] + m_freq[i];
        if (p >= PH_WRAP) p -= PH_WRAP;
        m_phase[i] = p;
        exp_x.push_back(p / 256);
        y = gen_y(p / 256);
        acc += (longint'($signed(y)) * longint'(m_gain[i])) >>> 16;
      end
    end
`ifdef OSC_MIX_SAT_EN
    if (acc > 64'sd8388607) acc = 8388607;
    if (acc < -64'sd8388608) acc = -8388608;
`endif
    em = 24'(acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int v, input bit en, input int f, input int g);
    @(negedge clk);
    cfg_we = 1'b1; cfg_voice = 2'(v); cfg_en = en; cfg_freq = 24'(f); cfg_gain = 16'(g);
    @(negedge clk);
    cfg_we = 1'b0;
    m_en[v]   = en;
    m_freq[v] = (f >= PH_WRAP) ? 'hBB7FFF : f;
    m_gain[v] = g;
  endtask

  // inject: 0 none, 1 extra tick during GMUL of the first voice, 2 tick during OUT
  task automatic do_frame(input string tag, input int inject);
    logic [23:0] em;
    int s0, mv0, ov0, c;
    model_frame(em);
    got_x.delete();
    s0 = n_start; mv0 = n_mv; ov0 = n_ov;
    chk({tag, "_idle_mult_a"}, mult_a, 0);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    if (inject == 1) begin
      c = 0;
      while (wave_finish !== 1'b1 && c < 200) begin @(posedge clk); c++; end
      chk({tag, "_finish_seen"}, wave_finish, 1);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
    c = 0;
    while (mix_valid !== 1'b1 && c < 2000) begin @(posedge clk); #1; c++; end
    chk({tag, "_mix_valid"}, mix_valid, 1);
    if (inject == 2) begin
      tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
    repeat (30) @(negedge clk);
    chk({tag, "_mix"}, mix, em);
    chk({tag, "_mv_count"}, n_mv - mv0, 1);
    chk({tag, "_ov_count"}, n_ov - ov0, (inject != 0) ? 1 : 0);
    chk({tag, "_starts"}, n_start - s0, exp_x.size());
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
      chk({tag, "_wave_x"}, got_x[i], exp_x[i]);
  endtask

  typedef struct {
    logic [3:0]        en;
    logic [3:0][23:0]  freq;
    logic [3:0][15:0]  gain;
    int                mode;
    logic [23:0]       gconst;
    logic [23:0]       exp_mix;
    int                exp_starts;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] en, input int f0, f1, f2, f3,
                               input int g0, g1, g2, g3, input int mode, input int gc,
                               input int em, input int es);
    vec_t r;
    r.en = en;
    r.freq[0] = 24'(f0); r.freq[1] = 24'(f1); r.freq[2] = 24'(f2); r.freq[3] = 24'(f3);
    r.gain[0] = 16'(g0); r.gain[1] = 16'(g1); r.gain[2] = 16'(g2); r.gain[3] = 16'(g3);
    r.mode = mode; r.gconst = 24'(gc); r.exp_mix = 24'(em); r.exp_starts = es;
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[7];
    int c, s0, mv0, nw, any;
    logic [23:0] dummy;

    tbl[0] = mkv(4'b0000, 'h03E800, 0, 0, 0, 'hFFFF, 0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mkv(4'b0001, 'h03E800, 0, 0, 0, 'hFFFF, 0, 0, 0, 0, 0, 'h03E7FC, 1);
    tbl[2] = mkv(4'b0001, 'h03E800, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tbl[3] = mkv(4'b1111, 'h100, 'h100, 'h100, 'h100, 'hFFFF, 'hFFFF, 'hFFFF, 'hFFFF,
                 1, 'h7FFFFF, E_FULL, 4);
    tbl[4] = mkv(4'b0111, 'h100, 'h100, 'h100, 0, 'h8000, 'h8000, 'h8000, 0,
                 1, 'h800000, E_NEG, 3);
    tbl[5] = mkv(4'b0001, 'hFFFFFF, 0, 0, 0, 'hFFFF, 0, 0, 0, 0, 0, 'hBB7F44, 1);
    tbl[6] = mkv(4'b0101, 'h006400, 'h010000, 'h00C880, 'h020000, 'h8000, 'hFFFF, 'h4000, 'hFFFF,
                 0, 0, 'h006400, 2);

    rst = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_voice = '0; cfg_en = 1'b0;
    cfg_freq = '0; cfg_gain = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wave_start", wave_start, 0);
    chk("rst_wave_x", wave_x, 0);
    chk("rst_mult_a", mult_a, 0);
    chk("rst_mult_b", mult_b, 0);
    chk("rst_mix", mix, 0);
    chk("rst_mix_valid", mix_valid, 0);
    chk("rst_overrun", overrun, 0);

    // Table vectors: each from reset, one frame
    for (int t = 0; t < 7; t++) begin
      do_reset();
      for (int i = 0; i < NV; i++)
        cfg_write(i, tbl[t].en[i], int'(tbl[t].freq[i]), int'(tbl[t].gain[i]));
      gen_mode  = tbl[t].mode;
      gen_const = tbl[t].gconst;
      s0 = n_start;
      do_frame($sformatf("tbl%0d", t), 0);
      chk($sformatf("tbl%0d_exp_mix", t), mix, tbl[t].exp_mix);
      chk($sformatf("tbl%0d_exp_starts", t), n_start - s0, tbl[t].exp_starts);
    end
    gen_mode = 0;

    // Reset while waiting on the generator aborts the frame
    do_reset();
    cfg_write(0, 1'b1, 'h03E800, 'hFFFF);
    gen_check_en = 1'b0; gen_dmin = 4; gen_dmax = 4;
    mv0 = n_mv;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    c = 0;
    while (wave_start !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
    chk("midrst_start_seen", wave_start, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wave_start", wave_start, 0);
    chk("midrst_wave_x", wave_x, 0);
    chk("midrst_mult_a", mult_a, 0);
    rst = 1'b0;
    s0 = n_start;
    repeat (20) @(negedge clk);
    chk("midrst_no_mix_valid", n_mv - mv0, 0);
    chk("midrst_no_restart", n_start - s0, 0);
    model_reset();
    gen_check_en = 1'b1; gen_dmin = 1; gen_dmax = 3;
    cfg_write(0, 1'b1, 'h03E800, 'hFFFF);
    do_frame("midrst_clean", 0);
    chk("midrst_clean_x", got_x.size() > 0 ? got_x[0] : -1, 1000);

    // Phase wrap: 1000 + 47999 -> 999
    do_reset();
    cfg_write(0, 1'b1, 'h03E800, 'hFFFF);
    do_frame("wrap_a", 0);
    cfg_write(0, 1'b1, 'hBB7F00, 'hFFFF);
    do_frame("wrap_b", 0);
    chk("wrap_x999", got_x.size() > 0 ? got_x[0] : -1, 999);

    // Overrun cases
    cfg_write(1, 1'b1, 'h012C00, 'h9000);
    do_frame("ovr_gmul", 1);
    do_frame("ovr_out", 2);

    // Disabled voice holds its phase
    do_reset();
    cfg_write(1, 1'b1, 5000 * 256, 'h1000);
    do_frame("hold_init", 0);
    cfg_write(1, 1'b0, 5000 * 256, 'h1000);
    cfg_write(0, 1'b1, 300 * 256, 'h2000);
    for (int k = 0; k < 3; k++) do_frame($sformatf("hold%0d", k), 0);
    cfg_write(1, 1'b1, 0, 'h1000);
    do_frame("hold_check", 0);
    chk("hold_phase5000", got_x.size() > 1 ? got_x[1] : -1, 5000);

    // Randomized frames
    for (int r = 0; r < 40; r++) begin
      nw = $urandom_range(3, 0);
      for (int w = 0; w < nw; w++)
        cfg_write($urandom_range(NV - 1, 0), 1'($urandom),
                  ($urandom_range(3, 0) == 0) ? $urandom_range('hFFFFFF, 0)
                                              : $urandom_range('hBB7FFF, 0),
                  $urandom_range('hFFFF, 0));
      gen_mode  = $urandom_range(2, 0);
      gen_const = 24'($urandom);
      any = 0;
      for (int i = 0; i < NV; i++) if (m_en[i]) any = 1;
      do_frame($sformatf("rnd%0d", r),
               any ? (($urandom_range(4, 0) < 2) ? $urandom_range(2, 1) : 0) : 0);
    end
    dummy = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
